// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Holds the funct3 op codes, the FSM state type and a conditional-negate helper.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result selection applied in the SIGN state.
// Negates the magnitude result when flagged and picks low/high word or quotient/remainder.
module muldiv_sign_fix
    import muldiv_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] rem_i,
    input  logic        neg_i,
    output logic [31:0] result_o
);

    logic [63:0] prod_d;

    always_comb begin
        prod_d   = neg_i ? (~acc_i + 64'd1) : acc_i;
        result_o = '0;
        case (op_i)
            F3_MUL:                      result_o = prod_d[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod_d[63:32];
            F3_DIV, F3_DIVU:             result_o = neg_if(acc_i[31:0], neg_i);
            default:                     result_o = neg_if(rem_i, neg_i);
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand magnitudes,
// sign fix-up afterwards, with a pipeline stall request held while an op is in flight.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] RS1data_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            stall_o
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("muldiv_unit: only XLEN=32 is supported");
        end
    endgenerate

    state_e      state_q;
    logic [2:0]  op_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] rem_q;
    logic [31:0] opb_q;
    logic        neg_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] result_q;

    logic        a_signed_d, b_signed_d, a_neg_d, b_neg_d, neg_start_d;
    logic [31:0] a_mag_d, b_mag_d, fast_res_d;
    logic        is_div_d, div_zero_d, div_ovf_d;
    logic [32:0] mul_sum_d, div_shift_d, div_diff_d;
    logic [31:0] fix_res_d;

    // Start-time decode: operand magnitudes, result sign and fast-path detection.
    always_comb begin
        a_signed_d  = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                      (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        b_signed_d  = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        a_neg_d     = a_signed_d & RS1data_i[31];
        b_neg_d     = b_signed_d & RS2data_i[31];
        a_mag_d     = neg_if(RS1data_i, a_neg_d);
        b_mag_d     = neg_if(RS2data_i, b_neg_d);
        neg_start_d = (funct3_i == F3_REM) ? a_neg_d : (a_neg_d ^ b_neg_d);
        is_div_d    = funct3_i[2];
        div_zero_d  = is_div_d && (RS2data_i == 32'd0);
        div_ovf_d   = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                      (RS1data_i == 32'h8000_0000) && (RS2data_i == 32'hFFFF_FFFF);
        if (div_zero_d) begin
            fast_res_d = funct3_i[1] ? RS1data_i : 32'hFFFF_FFFF;
        end else begin
            fast_res_d = funct3_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Multiply: acc holds {partial high word, remaining multiplier bits}.
    // Divide: acc[31:0] shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum_d   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        div_shift_d = {rem_q, acc_q[31]};
        div_diff_d  = div_shift_d - {1'b0, opb_q};
    end

    muldiv_sign_fix u_sign_fix (
        .op_i     (op_q),
        .acc_i    (acc_q),
        .rem_i    (rem_q),
        .neg_i    (neg_q),
        .result_o (fix_res_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q   <= funct3_i;
                        neg_q  <= neg_start_d;
                        busy_q <= 1'b1;
                        if (div_zero_d || div_ovf_d) begin
                            result_q <= fast_res_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            cnt_q   <= 5'd31;
                            rem_q   <= '0;
                            opb_q   <= is_div_d ? b_mag_d : a_mag_d;
                            acc_q   <= {32'd0, (is_div_d ? a_mag_d : b_mag_d)};
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        if (!div_diff_d[32]) begin
                            rem_q <= div_diff_d[31:0];
                        end else begin
                            rem_q <= div_shift_d[31:0];
                        end
                        acc_q <= {32'd0, acc_q[30:0], ~div_diff_d[32]};
                    end else begin
                        acc_q <= {mul_sum_d, acc_q[31:1]};
                    end
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    result_q <= fix_res_d;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign stall_o  = ((state_q == IDLE) && start_i) || (state_q == CALC) || (state_q == SIGN);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It consumes the RS1/RS2 operand values read from the register file and carried through ID/EX, and computes one M-extension op at a time over multiple cycles. While busy it holds the pipeline with a stall request. It releases the stall in the single cycle its result is valid, so the EX/MEM latch captures that result.

Parameters:
XLEN, 32, operand/result width; only 32 is supported; a non-32 value is an elaboration error.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  request an op; sampled only in IDLE
funct3_i  input  3  RV32M funct3 op select; sampled with start_i
RS1data_i  input  XLEN  operand a, sampled with start_i
RS2data_i  input  XLEN  operand b, sampled with start_i
flush_i  input  1  synchronous abort of the in-flight op
busy_o  input-independent output  1  high when state is not IDLE
done_o  output  1  one-cycle pulse; result_o valid this cycle
result_o  output  XLEN  registered result; holds until next completion
stall_o  output  1  combinational pipeline hold request

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset values: state IDLE, busy_o=0, done_o=0, result_o=0, iteration counter 0.
- Priority on each edge: rst_i, then flush_i, then normal operation.
- funct3 encodings:
  - 000 MUL: low word of product.
  - 001 MULH: high word, signed x signed.
  - 010 MULHSU: high word, signed a x unsigned b.
  - 011 MULHU: high word, unsigned x unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, CALC, SIGN, DONE.
- IDLE, start_i=1 on edge E0:
  - Latch op and operands.
  - Signed operands are converted to magnitudes; result negation flags are recorded.
  - Next state is CALC with counter 31, unless a fast path applies.
- Fast paths go straight to DONE; done_o is high in the cycle after E0.
  - Divisor zero: quotient = 0xFFFFFFFF, remainder = dividend (original signed value).
  - Signed overflow, DIV/REM with a=0x80000000 and b=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring shift-subtract over a 33-bit partial remainder.
  - Counter decrements each cycle; when it reaches 0, go to SIGN. CALC lasts exactly 32 cycles.
- SIGN: apply two's-complement negation per the recorded flags and select the high/low word or quotient/remainder into result_o.
  - Next state is DONE.
  - Remainder takes the sign of the dividend; quotient is negated when the operand signs differ.
- DONE: done_o=1 for exactly one cycle, then IDLE.
  - Normal latency: done_o is high in the 34th cycle after E0.
  - A back-to-back start is accepted the cycle after DONE, at the earliest.
- start_i outside IDLE is ignored; operands are not re-sampled.
- stall_o = (state==IDLE && start_i) || state==CALC || state==SIGN. It is low in DONE.
- flush_i in CALC, SIGN or DONE: next state IDLE, no done_o pulse, result_o unchanged.
- flush_i in IDLE with start_i: the start is dropped.
- rst_i mid-operation: all state goes to reset values at that edge.
- All arithmetic is internally unsigned. Operand sign extension to 33/64 bits is per op as listed above.

Decomposition:
- Package muldiv_pkg holds the funct3 localparams (MUL..REMU), the state encoding (IDLE, CALC, SIGN, DONE), and the XLEN default.
- No sub-module is required.
- Optional split: muldiv_sign_fix, a combinational negate/select used in SIGN. Everything else stays in one module.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result_o=0xFFFFFFEB; done_o in cycle 34 after start; stall_o high cycles 0..33, low at done.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU same -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done_o in cycle 1 after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each in cycle 1.
- Flush in CALC cycle 10 -> busy_o=0 next cycle; no done_o; result_o keeps its prior value. A subsequent MUL 3x4 -> 12 completes normally.
- rst_i at cycle 20 of a DIV -> busy_o=0, result_o=0, done_o=0 next cycle. start_i pulsed during CALC -> ignored; the original result is unchanged.
